// File: rtl/constraint_enumerator_if.sv
// Handshake bundle between the enumerator, its constraint checker and the hit consumer.
interface constraint_enumerator_if #(
  parameter int unsigned WA = 5,
  parameter int unsigned WB = 4
);
  logic               start;
  logic               first_only;
  logic               abort;
  logic [WA-1:0]      cand_a;
  logic [WB-1:0]      cand_b;
  logic               cand_valid;
  logic               sat_in;
  logic               hit_valid;
  logic               hit_ready;
  logic [WA-1:0]      hit_a;
  logic [WB-1:0]      hit_b;
  logic [WA+WB:0]     sat_count;
  logic               busy;
  logic               done;

  // Enumerator side
  modport master (
    input  start, first_only, abort, sat_in, hit_ready,
    output cand_a, cand_b, cand_valid, hit_valid, hit_a, hit_b, sat_count, busy, done
  );

  // Environment side: control, checker and hit consumer
  modport slave (
    output start, first_only, abort, sat_in, hit_ready,
    input  cand_a, cand_b, cand_valid, hit_valid, hit_a, hit_b, sat_count, busy, done
  );
endinterface

// File: rtl/constraint_enumerator.sv
// Walks every {A, B} assignment through an external combinational checker and
// streams each satisfying pair out over a valid/ready port while counting hits.
module constraint_enumerator #(
  parameter int unsigned WA = 5,
  parameter int unsigned WB = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  constraint_enumerator_if.master   bus
);
  localparam int unsigned IW = WA + WB;
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {StIdle, StScan, StHold, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WA-1:0]   hit_a_q, hit_a_d;
  logic [WB-1:0]   hit_b_q, hit_b_d;
  logic            fo_q, fo_d;
  logic            cand_valid_q, cand_valid_d;
  logic            hit_valid_q, hit_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            idx_last;

  assign idx_last = &idx_q;

  // Next-state logic; output flags are decoded from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hit_a_d = hit_a_q;
    hit_b_d = hit_b_q;
    fo_d    = fo_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StScan;
          idx_d   = '0;
          cnt_d   = '0;
          fo_d    = bus.first_only;
        end
      end
      StScan: begin
        if (bus.sat_in) begin
          hit_a_d = idx_q[IW-1:WB];
          hit_b_d = idx_q[WB-1:0];
          cnt_d   = cnt_q + 1'b1;
          state_d = StHold;
        end else if (idx_last) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StHold: begin
        if (bus.hit_ready) begin
          if (fo_q || idx_last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StScan;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over everything and leaves the captured results untouched.
    if (bus.abort) begin
      state_d = StIdle;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      hit_a_d = hit_a_q;
      hit_b_d = hit_b_q;
      fo_d    = fo_q;
    end
    cand_valid_d = (state_d == StScan);
    hit_valid_d  = (state_d == StHold);
    busy_d       = (state_d == StScan) || (state_d == StHold);
    done_d       = (state_d == StDone);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      hit_a_q      <= '0;
      hit_b_q      <= '0;
      fo_q         <= 1'b0;
      cand_valid_q <= 1'b0;
      hit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      hit_a_q      <= hit_a_d;
      hit_b_q      <= hit_b_d;
      fo_q         <= fo_d;
      cand_valid_q <= cand_valid_d;
      hit_valid_q  <= hit_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.cand_a     = idx_q[IW-1:WB];
  assign bus.cand_b     = idx_q[WB-1:0];
  assign bus.cand_valid = cand_valid_q;
  assign bus.hit_valid  = hit_valid_q;
  assign bus.hit_a      = hit_a_q;
  assign bus.hit_b      = hit_b_q;
  assign bus.sat_count  = cnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_constraint_enumerator.sv
// Bench for constraint_enumerator: models the checker, precomputes expected hits
// into a scoreboard queue and compares each accepted hit, counts and timing.
module tb_constraint_enumerator;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   sat_mode;
  logic [8:0] exp_q[$];

  constraint_enumerator_if #(.WA(5), .WB(4)) bus ();

  constraint_enumerator #(.WA(5), .WB(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker model: 0 = |(a & b), 1 = tied 0, 2 = tied 1
  function automatic logic model(input int mode, input logic [4:0] a, input logic [3:0] b);
    case (mode)
      0:       return |(a & {1'b0, b});
      1:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign bus.sat_in = model(sat_mode, bus.cand_a, bus.cand_b);

  // Runs one enumeration to DONE; compares every accepted hit against the scoreboard.
  task automatic do_run(input int mode, input bit fo, input int stall,
                        output int cyc, output int hits);
    logic [8:0] e;
    int held;
    sat_mode = mode;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      iv = 9'(i);
      if (model(mode, iv[8:4], iv[3:0]) && !(fo && exp_q.size() > 0)) exp_q.push_back(iv);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.first_only = fo;
    bus.hit_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = -1;
    hits = 0;
    held = 0;
    for (int n = 0; n < 4000; n++) begin
      if (bus.done) begin
        cyc = n;
        break;
      end
      if (bus.hit_valid) begin
        if (held < stall) begin
          held++;
          bus.hit_ready = 1'b0;
          checks++;
          if (bus.cand_valid !== 1'b0 || {bus.hit_a, bus.hit_b} !== exp_q[0] ||
              {bus.cand_a, bus.cand_b} !== exp_q[0]) begin
            errors++;
            $display("FAIL stall_hold: cand_valid=%b hit=%0h cand=%0h expected hit=cand=%0h",
                     bus.cand_valid, {bus.hit_a, bus.hit_b}, {bus.cand_a, bus.cand_b}, exp_q[0]);
          end
        end else begin
          bus.hit_ready = 1'b1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_hit: got %0h, expected no further hit", {bus.hit_a, bus.hit_b});
          end else begin
            e = exp_q.pop_front();
            if ({bus.hit_a, bus.hit_b} !== e) begin
              errors++;
              $display("FAIL hit_data: got %0h expected %0h", {bus.hit_a, bus.hit_b}, e);
            end
          end
          hits++;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL run_timeout: done never rose, expected done");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_hits: %0d hits left, expected 0", exp_q.size());
    end
    bus.hit_ready = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus.cand_a, bus.cand_b, bus.cand_valid, bus.hit_valid, bus.hit_a, bus.hit_b,
         bus.sat_count, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_state: cand=%0h cv=%b hv=%b hit=%0h cnt=%0d busy=%b done=%b expected all 0",
               {bus.cand_a, bus.cand_b}, bus.cand_valid, bus.hit_valid, {bus.hit_a, bus.hit_b},
               bus.sat_count, bus.busy, bus.done);
    end
  endtask

  task automatic test_full_scan();
    int cyc, hits;
    do_run(0, 1'b0, 0, cyc, hits);
    checks++;
    if (cyc !== 862) begin errors++; $display("FAIL full_cycles: got %0d expected 862", cyc); end
    checks++;
    if (hits !== 350) begin errors++; $display("FAIL full_hits: got %0d expected 350", hits); end
    checks++;
    if (bus.sat_count !== 10'd350) begin
      errors++; $display("FAIL full_count: got %0d expected 350", bus.sat_count);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.cand_valid !== 1'b0 || bus.hit_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_done_flags: busy=%b cv=%b hv=%b expected 0", bus.busy, bus.cand_valid,
               bus.hit_valid);
    end
  endtask

  task automatic test_first_only();
    int cyc, hits;
    do_run(0, 1'b1, 0, cyc, hits);
    checks++;
    if (hits !== 1 || cyc !== 19) begin
      errors++; $display("FAIL first_only_run: hits=%0d cycles=%0d expected 1 and 19", hits, cyc);
    end
    checks++;
    if (bus.hit_a !== 5'd1 || bus.hit_b !== 4'd1 || bus.sat_count !== 10'd1) begin
      errors++;
      $display("FAIL first_only_hit: a=%0d b=%0d cnt=%0d expected 1 1 1", bus.hit_a, bus.hit_b,
               bus.sat_count);
    end
  endtask

  task automatic test_backpressure();
    int cyc, hits;
    do_run(0, 1'b0, 10, cyc, hits);
    checks++;
    if (cyc !== 872 || hits !== 350 || bus.sat_count !== 10'd350) begin
      errors++;
      $display("FAIL backpressure: cycles=%0d hits=%0d cnt=%0d expected 872 350 350", cyc, hits,
               bus.sat_count);
    end
  endtask

  task automatic test_tied();
    int cyc, hits;
    do_run(1, 1'b0, 0, cyc, hits);
    checks++;
    if (cyc !== 512 || hits !== 0 || bus.sat_count !== 10'd0) begin
      errors++;
      $display("FAIL tied0: cycles=%0d hits=%0d cnt=%0d expected 512 0 0", cyc, hits,
               bus.sat_count);
    end
    do_run(2, 1'b0, 0, cyc, hits);
    checks++;
    if (cyc !== 1024 || hits !== 512 || bus.sat_count !== 10'd512) begin
      errors++;
      $display("FAIL tied1: cycles=%0d hits=%0d cnt=%0d expected 1024 512 512", cyc, hits,
               bus.sat_count);
    end
  endtask

  task automatic test_abort();
    int n;
    sat_mode = 0;
    bus.hit_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.first_only = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.hit_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.hit_valid) begin errors++; $display("FAIL abort_wait: no hit_valid, expected one"); end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hit_valid !== 1'b0 || bus.cand_valid !== 1'b0 ||
        bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b hv=%b cv=%b done=%b expected 0", bus.busy, bus.hit_valid,
               bus.cand_valid, bus.done);
    end
    checks++;
    if (bus.sat_count !== 10'd1 || bus.hit_a !== 5'd1 || bus.hit_b !== 4'd1) begin
      errors++;
      $display("FAIL abort_keep: cnt=%0d a=%0d b=%0d expected 1 1 1", bus.sat_count, bus.hit_a,
               bus.hit_b);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.sat_count !== 10'd0 || {bus.cand_a, bus.cand_b} !== 9'd0 || bus.cand_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: cnt=%0d cand=%0d cv=%b expected 0 0 1", bus.sat_count,
               {bus.cand_a, bus.cand_b}, bus.cand_valid);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.hit_ready = 1'b1;
  endtask

  task automatic test_busy_start_and_async_reset();
    sat_mode = 0;
    bus.hit_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.first_only = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.cand_a, bus.cand_b} !== 9'd0 || bus.cand_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_cand: cand=%0d cv=%b expected 0 1", {bus.cand_a, bus.cand_b},
               bus.cand_valid);
    end
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.cand_a, bus.cand_b} !== 9'd6 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: cand=%0d busy=%b expected 6 1", {bus.cand_a, bus.cand_b}, bus.busy);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (bus.sat_count == 10'd0) begin
      errors++; $display("FAIL pre_reset_count: got 0 expected nonzero");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.cand_a, bus.cand_b, bus.cand_valid, bus.hit_valid, bus.hit_a, bus.hit_b,
         bus.sat_count, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL async_reset: cand=%0h cv=%b hv=%b hit=%0h cnt=%0d busy=%b done=%b expected 0",
               {bus.cand_a, bus.cand_b}, bus.cand_valid, bus.hit_valid, {bus.hit_a, bus.hit_b},
               bus.sat_count, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sat_mode = 0;
    bus.start = 1'b0;
    bus.first_only = 1'b0;
    bus.abort = 1'b0;
    bus.hit_ready = 1'b1;
    rst = 1'b1;
    test_reset();
    #20 rst = 1'b0;
    test_full_scan();
    test_first_only();
    test_backpressure();
    test_tied();
    test_abort();
    test_busy_start_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
